// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        FULL  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [XLEN-1:0] NOP_INSTR  = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP    = 32'd4;
    localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

    // One instruction slot: word plus the address it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_slot_t;

    function automatic logic [XLEN-1:0] pc_next(input logic [XLEN-1:0] pc);
        return XLEN'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem reads, registered IR with skid buffer.
// Optional MISALIGN_TRAP_EN: misaligned redirects raise a sticky fetch_misalign and stall fetch.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] ir,
    output logic [XLEN-1:0] ir_pc,
    output logic            ir_valid,
    input  logic            id_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef MISALIGN_TRAP_EN
    ,
    output logic            fetch_misalign
`endif
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    fetch_slot_t     ir_q, ir_d;
    fetch_slot_t     skid_q, skid_d;
    logic            ir_valid_q, ir_valid_d;
    logic            misalign_q, misalign_d;
    logic            req_c;

`ifdef MISALIGN_TRAP_EN
    assign req_c = (state_q == ISSUE) && !misalign_q;
    assign fetch_misalign = misalign_q;
`else
    assign req_c = (state_q == ISSUE);
`endif

    assign imem_req  = req_c;
    assign imem_addr = pc_q;
    assign ir        = ir_q.instr;
    assign ir_pc     = ir_q.pc;
    assign ir_valid  = ir_valid_q;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ISSUE;
            pc_q       <= RESET_PC;
            ir_q       <= '{instr: NOP_INSTR, pc: RESET_PC};
            skid_q     <= '{instr: NOP_INSTR, pc: RESET_PC};
            ir_valid_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            skid_q     <= skid_d;
            ir_valid_q <= ir_valid_d;
            misalign_q <= misalign_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        skid_d     = skid_q;
        ir_valid_d = ir_valid_q;
        misalign_d = misalign_q;

        if (ir_valid_q && id_ready) begin
            ir_valid_d = 1'b0;
        end

        case (state_q)
            ISSUE: begin
                state_d = req_c ? WAIT : ISSUE;
            end
            WAIT: begin
                if (imem_valid) begin
                    pc_d = pc_next(pc_q);
                    if (!ir_valid_q || id_ready) begin
                        ir_d       = '{instr: imem_rdata, pc: pc_q};
                        ir_valid_d = 1'b1;
                        state_d    = ISSUE;
                    end else begin
                        skid_d  = '{instr: imem_rdata, pc: pc_q};
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                if (id_ready) begin
                    ir_d       = skid_q;
                    ir_valid_d = 1'b1;
                    state_d    = ISSUE;
                end
            end
            DRAIN: begin
                if (imem_valid) begin
                    state_d = ISSUE;
                end
            end
            default: state_d = ISSUE;
        endcase

        // Redirect overrides everything; an outstanding request must be drained first.
        if (redirect) begin
            ir_d       = ir_q;
            skid_d     = skid_q;
            ir_valid_d = 1'b0;
`ifdef MISALIGN_TRAP_EN
            pc_d       = redirect_pc;
            misalign_d = (redirect_pc[1:0] != 2'b00);
`else
            pc_d       = redirect_pc & ALIGN_MASK;
`endif
            case (state_q)
                ISSUE:       state_d = req_c ? DRAIN : ISSUE;
                WAIT, DRAIN: state_d = imem_valid ? ISSUE : DRAIN;
                default:     state_d = ISSUE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with RESET_PC=32'h100.
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'h5A5A_0000;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        id_ready;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef MISALIGN_TRAP_EN
    logic        fetch_misalign;
`endif

    fetch_stage #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_valid    (imem_valid),
        .imem_rdata    (imem_rdata),
        .ir            (ir),
        .ir_pc         (ir_pc),
        .ir_valid      (ir_valid),
        .id_ready      (id_ready),
        .redirect      (redirect),
        .redirect_pc   (redirect_pc)
`ifdef MISALIGN_TRAP_EN
        ,
        .fetch_misalign(fetch_misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        iv;
        logic [31:0] rdata;
        logic        rdy;
        logic        rd;
        logic [31:0] rpc;
        logic        chk;
        logic        req;
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] irpc;
        logic        irv;
        logic        mis;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic vec_t mk(input logic r, input logic iv, input logic [31:0] rdata,
                                input logic rdy, input logic rd, input logic [31:0] rpc,
                                input logic chk, input logic req, input logic [31:0] addr,
                                input logic [31:0] e_ir, input logic [31:0] e_irpc,
                                input logic irv, input logic mis);
        vec_t v;
        v.rst_n = r;   v.iv = iv;   v.rdata = rdata; v.rdy = rdy;
        v.rd = rd;     v.rpc = rpc; v.chk = chk;     v.req = req;
        v.addr = addr; v.ir = e_ir; v.irpc = e_irpc; v.irv = irv; v.mis = mis;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] exp_pc;
        logic        pending;
        logic [31:0] pend_addr;
        int          got;

        rst_n = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        id_ready = 1'b0; redirect = 1'b0; redirect_pc = '0;

        //                rst iv rdata          rdy rd rpc            chk req addr           ir             irpc           irv mis
        vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,          0, 0, 32'h0,          32'h0,         32'h0,         0, 0));
        // streaming at 1-cycle latency
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h100,        32'h13,        32'h100,       0, 0));
        vecs.push_back(mk(1, 1, 32'hAAA0_0001,  1, 0, 32'h0,          1, 0, 32'h100,        32'h13,        32'h100,       0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h104,        32'hAAA0_0001, 32'h100,       1, 0));
        vecs.push_back(mk(1, 1, 32'hAAA0_0002,  1, 0, 32'h0,          1, 0, 32'h104,        32'hAAA0_0001, 32'h100,       0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h108,        32'hAAA0_0002, 32'h104,       1, 0));
        vecs.push_back(mk(1, 1, 32'hAAA0_0003,  1, 0, 32'h0,          1, 0, 32'h108,        32'hAAA0_0002, 32'h104,       0, 0));
        // back-pressure: second word lands in the skid buffer
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h10C,        32'hAAA0_0003, 32'h108,       1, 0));
        vecs.push_back(mk(1, 1, 32'hAAA0_0004,  0, 0, 32'h0,          1, 0, 32'h10C,        32'hAAA0_0003, 32'h108,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h110,        32'hAAA0_0003, 32'h108,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 0, 32'h110,        32'hAAA0_0003, 32'h108,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h110,        32'hAAA0_0003, 32'h108,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h110,        32'hAAA0_0004, 32'h10C,       1, 0));
        // redirect while waiting, stale response at latency 3
        vecs.push_back(mk(1, 0, 32'h0,          1, 1, 32'h2000,       1, 0, 32'h110,        32'hAAA0_0004, 32'h10C,       0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h2000,       32'hAAA0_0004, 32'h10C,       0, 0));
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1, 0, 32'h2000,       32'hAAA0_0004, 32'h10C,       0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h2000,       32'hAAA0_0004, 32'h10C,       0, 0));
        vecs.push_back(mk(1, 1, 32'hBBB0_0000,  1, 0, 32'h0,          1, 0, 32'h2000,       32'hAAA0_0004, 32'h10C,       0, 0));
        // redirect coincident with the response
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h2004,       32'hBBB0_0000, 32'h2000,      1, 0));
        vecs.push_back(mk(1, 1, 32'hCCC0_0000,  1, 1, 32'h3000,       1, 0, 32'h2004,       32'hBBB0_0000, 32'h2000,      1, 0));
        // redirect from ISSUE drains the request, then PC wrap
        vecs.push_back(mk(1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  1, 1, 32'h3000,       32'hBBB0_0000, 32'h2000,      0, 0));
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1, 0, 32'hFFFF_FFFC,  32'hBBB0_0000, 32'h2000,      0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'hFFFF_FFFC,  32'hBBB0_0000, 32'h2000,      0, 0));
        vecs.push_back(mk(1, 1, 32'hCCC0_0001,  1, 0, 32'h0,          1, 0, 32'hFFFF_FFFC,  32'hBBB0_0000, 32'h2000,      0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h0,          32'hCCC0_0001, 32'hFFFF_FFFC, 1, 0));
        // misaligned redirect
        vecs.push_back(mk(1, 0, 32'h0,          1, 1, 32'h2002,       1, 0, 32'h0,          32'hCCC0_0001, 32'hFFFF_FFFC, 0, 0));
`ifdef MISALIGN_TRAP_EN
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1, 0, 32'h2002,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 1));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h2002,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 1));
        vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h2002,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 1));
`else
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF,  1, 0, 32'h0,          1, 0, 32'h2000,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h2000,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,          1, 0, 32'h2000,       32'hCCC0_0001, 32'hFFFF_FFFC, 0, 0));
`endif
        // reset mid-request: late response arrives during ISSUE and is ignored
        vecs.push_back(mk(1, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,          1, 1, 32'h100,        32'h13,        32'h100,       0, 0));
        vecs.push_back(mk(1, 1, 32'hDDD0_0000,  1, 0, 32'h0,          1, 0, 32'h100,        32'h13,        32'h100,       0, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,          1, 1, 32'h104,        32'hDDD0_0000, 32'h100,       1, 0));
        // redirect out of FULL
        vecs.push_back(mk(1, 1, 32'hDDD0_0001,  0, 0, 32'h0,          1, 0, 32'h104,        32'hDDD0_0000, 32'h100,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          0, 1, 32'h4000,       1, 0, 32'h108,        32'hDDD0_0000, 32'h100,       1, 0));
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,          1, 1, 32'h4000,       32'hDDD0_0000, 32'h100,       0, 0));

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n       = vecs[i].rst_n;
            imem_valid  = vecs[i].iv;
            imem_rdata  = vecs[i].rdata;
            id_ready    = vecs[i].rdy;
            redirect    = vecs[i].rd;
            redirect_pc = vecs[i].rpc;
            #1;
            if (vecs[i].chk) begin
                check($sformatf("v%0d imem_req", i),  32'(imem_req),  32'(vecs[i].req));
                check($sformatf("v%0d imem_addr", i), imem_addr,      vecs[i].addr);
                check($sformatf("v%0d ir", i),        ir,             vecs[i].ir);
                check($sformatf("v%0d ir_pc", i),     ir_pc,          vecs[i].irpc);
                check($sformatf("v%0d ir_valid", i),  32'(ir_valid),  32'(vecs[i].irv));
`ifdef MISALIGN_TRAP_EN
                check($sformatf("v%0d misalign", i),  32'(fetch_misalign), 32'(vecs[i].mis));
`endif
            end
        end

        // Free-running stream from 0x4000 with a 1-cycle memory; the last vector issued 0x4000.
        pending   = 1'b1;
        pend_addr = 32'h4000;
        exp_pc    = 32'h4000;
        got       = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            redirect   = 1'b0;
            id_ready   = 1'b1;
            imem_valid = pending;
            imem_rdata = pend_addr ^ KEY;
            #1;
            if (ir_valid) begin
                check($sformatf("stream%0d ir_pc", got), ir_pc, exp_pc);
                check($sformatf("stream%0d ir", got),    ir,    exp_pc ^ KEY);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            pending   = imem_req;
            pend_addr = imem_addr;
        end
        check("stream throughput", 32'(got >= 8), 32'd1);

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
